// File: rtl/mult_pkg.sv
// Shared types and Booth decode constants for the radix-2 Booth multiplier.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // {Q0, Q_-1} pairs that call for a partial-product update.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  localparam logic ADD_SEL = 1'b1;

endpackage

// File: rtl/booth_sequencer.sv
// Sequencer for the radix-2 Booth datapath: one run per rising edge of start,
// N evaluate/shift iterations, then a held result-valid flag.
module booth_sequencer
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic [1:0] q_LSB,
  output logic       load_A,
  output logic       load_B,
  output logic       load_add,
  output logic       add_sub,
  output logic       shift_HQ_LQ_Q_1,
  output logic       busy,
  output logic       done,
  output logic       result_valid
);

  localparam int CW = $clog2(N + 1);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic          start_q;
  logic          valid_q;
  logic          launch;
  logic          abort;

  assign launch = start & ~start_q;
  assign abort  = rst | clear;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      start_q <= start;
      if (clear) begin
        // The edge seen in this cycle is consumed, not deferred.
        state   <= IDLE;
        valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (launch) begin
              state   <= LOAD;
              valid_q <= 1'b0;
              cnt     <= CW'(N);
            end
          end
          LOAD:  state <= EVAL;
          EVAL:  state <= SHIFT;
          SHIFT: begin
            cnt   <= cnt - CW'(1);
            state <= (cnt == CW'(1)) ? DONE : EVAL;
          end
          DONE: begin
            valid_q <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    load_A          = 1'b0;
    load_B          = 1'b0;
    load_add        = 1'b0;
    add_sub         = 1'b0;
    shift_HQ_LQ_Q_1 = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    result_valid    = 1'b0;
    if (!abort) begin
      result_valid = valid_q;
      case (state)
        LOAD: begin
          load_A = 1'b1;
          load_B = 1'b1;
          busy   = 1'b1;
        end
        EVAL: begin
          busy = 1'b1;
          if (q_LSB == BOOTH_ADD) begin
            load_add = 1'b1;
            add_sub  = ADD_SEL;
          end else if (q_LSB == BOOTH_SUB) begin
            load_add = 1'b1;
            add_sub  = ~ADD_SEL;
          end
        end
        SHIFT: begin
          shift_HQ_LQ_Q_1 = 1'b1;
          busy            = 1'b1;
        end
        DONE: begin
          done         = 1'b1;
          result_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer with an attached behavioural Booth datapath and
// a product scoreboard checked whenever done pulses.
module tb_booth_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clear;
  logic [1:0] q_lsb;
  logic       load_a, load_b, load_add, add_sub, shift, busy, done, result_valid;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  booth_sequencer #(.N(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .clear           (clear),
    .q_LSB           (q_lsb),
    .load_A          (load_a),
    .load_B          (load_b),
    .load_add        (load_add),
    .add_sub         (add_sub),
    .shift_HQ_LQ_Q_1 (shift),
    .busy            (busy),
    .done            (done),
    .result_valid    (result_valid)
  );

  // Behavioural datapath: M, HQ, LQ, Q_-1 driven by the sequencer strobes.
  logic [7:0] a_op = '0, b_op = '0;
  logic [7:0] m_r = '0, hq = '0, lq = '0;
  logic       q1 = 1'b0;

  always @(posedge clk) begin
    if (load_a) m_r <= a_op;
    if (load_b) begin
      lq <= b_op;
      hq <= '0;
      q1 <= 1'b0;
    end else if (load_add) begin
      hq <= add_sub ? hq + m_r : hq - m_r;
    end else if (shift) begin
      {hq, lq, q1} <= {hq[7], hq, lq};
    end
  end

  assign q_lsb = {lq[0], q1};

  logic [15:0] exp_q[$];

  typedef struct {
    int          done_cyc;
    int          n_done;
    int          n_load;
    int          first_load;
    int          n_bad;
    logic [7:0]  snap;
    logic        rv_end;
  } obs_t;

  function automatic logic [7:0] outs();
    return {load_a, load_b, load_add, add_sub, shift, busy, done, result_valid};
  endfunction

  // Leaves start low for one cycle, then raises it so the next edge is cycle 0.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit expect_done);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a_op  = a;
    b_op  = b;
    start = 1'b1;
    if (expect_done)
      exp_q.push_back(16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b})));
  endtask

  // Runs cycles 1..ncyc after a launch, driving scheduled events and gathering
  // observations; the product scoreboard is compared on every done pulse.
  task automatic watch(input int ncyc, input int snap_at, input int clear_at,
                       input int rst_at, input int start_lo_at, input int start_hi_at,
                       output obs_t o);
    logic [7:0] v;
    bit         eval_c;
    o = '{done_cyc: -1, n_done: 0, n_load: 0, first_load: -1, n_bad: 0,
          snap: 8'hxx, rv_end: 1'bx};
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      if (i == clear_at) clear = 1'b1;
      else if (i == clear_at + 1) clear = 1'b0;
      if (i == rst_at) begin
        rst   = 1'b1;
        start = 1'b0;
      end else if (i == rst_at + 1) begin
        rst = 1'b0;
      end
      if (i == start_lo_at) start = 1'b0;
      if (i == start_hi_at) start = 1'b1;
      @(negedge clk);
      v = outs();
      if (i == snap_at) o.snap = v;
      o.rv_end = result_valid;
      if (load_a) begin
        o.n_load++;
        if (o.first_load < 0) o.first_load = i;
      end
      if ((32'(load_a | load_b) + 32'(load_add) + 32'(shift)) > 1) o.n_bad++;
      if (load_a !== load_b) o.n_bad++;
      if (add_sub && !load_add) o.n_bad++;
      eval_c = busy && !load_a && !shift;
      if (eval_c) begin
        if (load_add !== (q_lsb == 2'b01 || q_lsb == 2'b10)) o.n_bad++;
        if (load_add && add_sub !== (q_lsb == 2'b01)) o.n_bad++;
      end else if (load_add) begin
        o.n_bad++;
      end
      if (done) begin
        o.n_done++;
        o.done_cyc = i;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL product: got %h with no product expected", {hq, lq});
        end else if ({hq, lq} !== exp_q[0]) begin
          $display("FAIL product: got %h expected %h", {hq, lq}, exp_q[0]);
        end else begin
          n_pass++;
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; start = 1'b1; clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (outs() !== 8'h00) $display("FAIL reset_outputs: got %b expected 00000000", outs());
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (outs() !== 8'h00) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL idle_after_reset: got %0d busy cycles expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_basic();
    obs_t o;
    launch(8'd3, 8'd5, 1'b1);
    watch(21, 1, -1, -1, -1, -1, o);
    n_total++;
    if (o.first_load !== 1) $display("FAIL basic_load_cycle: got %0d expected 1", o.first_load);
    else n_pass++;
    n_total++;
    if (o.snap !== 8'b1100_0100) $display("FAIL basic_load_outs: got %b expected 11000100", o.snap);
    else n_pass++;
    n_total++;
    if (o.done_cyc !== 18 || o.n_done !== 1)
      $display("FAIL basic_done: got cycle %0d count %0d expected cycle 18 count 1", o.done_cyc, o.n_done);
    else n_pass++;
    n_total++;
    if (o.n_bad !== 0) $display("FAIL basic_strobes: got %0d bad cycles expected 0", o.n_bad);
    else n_pass++;
    n_total++;
    if (o.rv_end !== 1'b1) $display("FAIL basic_result_valid: got %b expected 1", o.rv_end);
    else n_pass++;
  endtask

  task automatic test_hold_start();
    obs_t o;
    watch(40, -1, -1, -1, -1, -1, o);
    n_total++;
    if (o.n_done !== 0 || o.n_load !== 0)
      $display("FAIL hold_retrigger: got done %0d load %0d expected 0 0", o.n_done, o.n_load);
    else n_pass++;
    n_total++;
    if (o.rv_end !== 1'b1) $display("FAIL hold_result_valid: got %b expected 1", o.rv_end);
    else n_pass++;
  endtask

  task automatic test_negative();
    obs_t o;
    launch(8'hFD, 8'd6, 1'b1);
    watch(20, -1, -1, -1, -1, -1, o);
    n_total++;
    if (o.done_cyc !== 18 || o.n_bad !== 0)
      $display("FAIL negative_run: got done %0d bad %0d expected 18 0", o.done_cyc, o.n_bad);
    else n_pass++;
    n_total++;
    if ({hq, lq} !== 16'hFFEE) $display("FAIL negative_y: got %h expected ffee", {hq, lq});
    else n_pass++;
  endtask

  task automatic test_clear();
    obs_t o;
    launch(8'd7, 8'd9, 1'b0);
    watch(25, 10, 9, -1, -1, -1, o);
    n_total++;
    if (o.snap !== 8'h00) $display("FAIL clear_idle: got %b expected 00000000", o.snap);
    else n_pass++;
    n_total++;
    if (o.n_done !== 0 || o.rv_end !== 1'b0)
      $display("FAIL clear_abort: got done %0d valid %b expected 0 0", o.n_done, o.rv_end);
    else n_pass++;
    launch(8'hFB, 8'hF9, 1'b1);
    watch(20, -1, -1, -1, -1, -1, o);
    n_total++;
    if (o.done_cyc !== 18 || o.n_bad !== 0)
      $display("FAIL clear_relaunch: got done %0d bad %0d expected 18 0", o.done_cyc, o.n_bad);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    obs_t o;
    launch(8'd2, 8'd3, 1'b0);
    watch(25, 6, -1, 5, -1, -1, o);
    n_total++;
    if (o.snap !== 8'h00) $display("FAIL rst_mid_outs: got %b expected 00000000", o.snap);
    else n_pass++;
    n_total++;
    if (o.n_done !== 0 || o.n_load !== 1)
      $display("FAIL rst_mid_abort: got done %0d load %0d expected 0 1", o.n_done, o.n_load);
    else n_pass++;
    launch(8'd12, 8'hFC, 1'b1);
    watch(20, -1, -1, -1, -1, -1, o);
    n_total++;
    if (o.done_cyc !== 18) $display("FAIL rst_relaunch: got done %0d expected 18", o.done_cyc);
    else n_pass++;
  endtask

  task automatic test_busy_edge();
    obs_t o;
    launch(8'd11, 8'd13, 1'b1);
    watch(40, -1, -1, -1, 6, 7, o);
    n_total++;
    if (o.n_done !== 1 || o.done_cyc !== 18 || o.n_load !== 1)
      $display("FAIL busy_edge: got done %0d at %0d load %0d expected 1 at 18 load 1",
               o.n_done, o.done_cyc, o.n_load);
    else n_pass++;
    n_total++;
    if (o.n_bad !== 0) $display("FAIL busy_edge_strobes: got %0d bad cycles expected 0", o.n_bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_start();
    test_negative();
    test_clear();
    test_rst_mid();
    test_busy_edge();
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/booth_sequencer.md
# booth_sequencer

Cycle-exact controller for the radix-2 Booth multiplier datapath (`mult_with_no_fsm`). It converts a level-type start request (the operand-ready flag from operand entry) into a single multiply run. It issues load, add/sub and shift strobes for exactly `N` iterations, and then holds a result-valid flag for the display mux. It runs on the divided clock domain alongside the datapath.

## Interface
- `N`, default 8: operand width; the multiply performs `N` Booth iterations.
- `clk` input 1: clock; the same divided clock that drives the datapath.
- `rst` input 1: one clock; reset is synchronous and active-high.
- `start` input 1: level request; only its 0→1 transition launches a run.
- `clear` input 1: synchronous abort; return to IDLE and drop `result_valid`.
- `q_LSB` input 2: datapath `{Q0, Q_-1}`, sampled in EVAL.
- `load_A` output 1: multiplicand register load strobe.
- `load_B` output 1: multiplier load strobe; the datapath also clears HQ and Q_-1 on this strobe.
- `load_add` output 1: HQ ← HQ ± M strobe.
- `add_sub` output 1: 1 = add, 0 = subtract; meaningful only while `load_add`=1.
- `shift_HQ_LQ_Q_1` output 1: arithmetic right shift strobe for {HQ, LQ, Q_-1}.
- `busy` output 1: high from LOAD through the last SHIFT.
- `done` output 1: one-cycle pulse when the product is final.
- `result_valid` output 1: level; high from DONE until the next accepted start, `clear` or `rst`.

## Operation
- **States**: IDLE, LOAD, EVAL, SHIFT, DONE.
- **Start detection**: `start` is registered into `start_q`. A launch requires `start & ~start_q`. A start held high never retriggers. A rising edge outside IDLE is ignored and is not queued.
- **IDLE**
  - All strobes are 0.
  - On a launch, go to LOAD, clear `result_valid`, and load iteration counter `cnt` ← N.
- **LOAD**
  - Assert `load_A` and `load_B` for one cycle, then go to EVAL.
- **EVAL**: decode `q_LSB`.
  - 2'b01: `load_add`=1, `add_sub`=1.
  - 2'b10: `load_add`=1, `add_sub`=0.
  - 2'b00 or 2'b11: no strobe.
  - Always go to SHIFT next.
- **SHIFT**
  - Assert `shift_HQ_LQ_Q_1` and set `cnt` ← `cnt`-1.
  - If `cnt` was 1, go to DONE; otherwise go to EVAL.
- **DONE**
  - Set `done`=1 for one cycle and `result_valid` ← 1, then go to IDLE.
- **Strobe exclusivity**: at most one of {`load_A`/`load_B` pair, `load_add`, `shift_HQ_LQ_Q_1`} is active in any cycle.
- **Outputs are combinational from state**: all are Moore outputs, except `load_add` and `add_sub`, which also depend on `q_LSB`. When `load_add`=0, `add_sub` is driven to 0.
- **Counter**: `cnt` is `$clog2(N+1)` bits wide. It never wraps, because it is reloaded on every launch.
- **`clear`**: in any state, the next state is IDLE and `result_valid`=0, and no strobe is asserted in that cycle. If `clear` and a launch edge occur in the same cycle, `clear` wins and the edge is consumed (`start_q` still updates).
- **`rst`**: same effect as `clear`, and it additionally sets `start_q`←0.

## Timing
- **Reset values**: state IDLE; `cnt`=0; `start_q`=0. Outputs `load_A`, `load_B`, `load_add`, `add_sub`, `shift_HQ_LQ_Q_1`, `busy`, `done` and `result_valid` are all 0.
- **Cycle numbering**: cycle 0 is the edge where IDLE samples the launch.
  - LOAD in cycle 1.
  - EVAL in cycles 2, 4, …, 2N.
  - SHIFT in cycles 3, 5, …, 2N+1.
  - DONE in cycle 2N+2 (18 for N=8).
- **Latency**: fixed, independent of operand values.
- **`q_LSB` sampling**: `q_LSB` in EVAL reflects the datapath after the preceding LOAD or SHIFT edge. The datapath is fully registered, so there is no combinational loop.
- **Re-launch**: the earliest re-launch is a new rising edge sampled in the cycle after DONE. `start` must first return to 0 for at least one cycle.
- **Reset mid-run**: the datapath is not cleared by this block. The next LOAD reinitialises it.

## Structure
- **Shared package `mult_pkg`**:
  - `typedef enum logic [2:0] seq_state_t` for {IDLE, LOAD, EVAL, SHIFT, DONE}.
  - Booth decode constants `BOOTH_ADD`=2'b01 and `BOOTH_SUB`=2'b10.
  - Constant `ADD_SEL`=1'b1.
- **Single module**: no sub-module. The edge detector is two lines inline.
- **Integration**: `booth_sequencer` replaces the existing sequencing instance at top level. `start` is driven by `signal_num`.

## Test plan
- Reset, then `start` 0→1 with A=3, B=5 (datapath model attached):
  - `load_A`/`load_B` in cycle 1.
  - `done` in cycle 18.
  - Y=15, and `result_valid` stays high while `start` remains high.
- A=-3 (8'hFD), B=6: per-iteration `q_LSB` drives the correct `add_sub`. Y=16'hFFEE (-18) at cycle 18.
- `start` held high for 40 cycles after a completed run: exactly one `done`; no second LOAD.
- `clear` asserted in cycle 9 of a run:
  - Idle with all strobes 0 in cycle 10.
  - `result_valid`=0 and no `done`.
  - A fresh edge afterwards completes normally at +18.
- `rst` asserted during SHIFT, and also with `start` high during reset: all outputs are 0 the next cycle. A run starts only after `start` is seen low, then high.
- Rising edge on `start` while busy (cycle 7): ignored. `done` occurs only once, at cycle 18 of the original run.
